bus_fabric: RTL
===============

BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 Parameter NREG, default 4: number of decoded slave regions, range 1..8.
REQ-002 Parameter AW, default 16: CPU address width.
REQ-003 Parameter DW, default 8: data width.
REQ-004 Parameter BASE, default {16'h6000,16'h5000,16'h8000,16'h0000}: packed NREG*AW region base addresses; region i occupies bits [i*AW +: AW].
REQ-005 Parameter MASK, default {16'hF000,16'hF000,16'h8000,16'hC000}: packed NREG*AW compare masks, one per region.
REQ-006 Parameter WS, default {4'd0,4'd2,4'd0,4'd0}: packed NREG*4 wait-state counts, one per region.
REQ-007 Parameter DFLT_DATA, default 8'hFF: read data returned for unmapped addresses.
REQ-008 Ports, in order:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_ad  in  AW  CPU address.
- cpu_we  in  1  CPU write enable, active high.
- cpu_do  in  DW  CPU write data.
- cpu_di  out  DW  read data to CPU.
- cpu_rdy  out  1  ready to CPU; low stalls the CPU.
- s_cs  out  NREG  one-hot slave selects.
- s_we  out  1  slave write strobe.
- s_addr  out  AW  slave address, equal to cpu_ad.
- s_wdata  out  DW  slave write data, equal to cpu_do.
- s_rdata  in  NREG*DW  packed slave read data; slave i drives [i*DW +: DW].
- err_clr  in  1  clears the error flag.
- err  out  1  sticky unmapped-access flag.
- err_addr  out  AW  address of the first unmapped access.

Function
REQ-009 Region i SHALL hit when (cpu_ad & MASK_i) == BASE_i. When several regions hit, the lowest index SHALL win. When no region hits, the access is unmapped.
REQ-010 s_cs SHALL be combinational from cpu_ad. It is one-hot on the winning region and all-zero when the access is unmapped or rst is low.
REQ-011 The FSM SHALL have two states, IDLE and WAIT, and a 4-bit down-counter cnt.
REQ-012 IDLE, hit region i with WS_i=0: cpu_rdy=1; the state stays IDLE.
REQ-013 IDLE, hit region i with WS_i>0: cpu_rdy=0; cnt is loaded with WS_i-1; the next state is WAIT.
REQ-014 WAIT, cnt!=0: cpu_rdy=0; cnt decrements.
REQ-015 WAIT, cnt==0: cpu_rdy=1; the next state is IDLE.
REQ-016 Net effect of REQ-012..015: cpu_rdy is low for exactly WS_i consecutive cycles per access, beginning in the cycle the address is first presented.
REQ-017 s_cs and s_addr SHALL remain asserted and stable throughout the wait cycles, because the CPU holds cpu_ad while cpu_rdy is low.
REQ-018 s_we SHALL equal cpu_we & cpu_rdy & (access is mapped). Exactly one write strobe is issued per access, in its completing cycle.
REQ-019 Unmapped writes SHALL be dropped. Unmapped accesses SHALL never insert wait states.
REQ-020 Read latency is one cycle; slaves have synchronous reads.
- sel_q SHALL register the winning region index, or "none", on every rising edge where cpu_rdy=1; it holds otherwise.
- cpu_di = s_rdata slice of sel_q, or DFLT_DATA when sel_q is "none".
REQ-021 In every completing cycle (cpu_rdy=1) of an unmapped access, err SHALL set.
- err_addr SHALL capture cpu_ad only if err was 0 beforehand.
- When err_clr and a set occur in the same cycle, the set SHALL win and err_addr SHALL load the new address.
REQ-022 err_clr alone SHALL clear err on the next edge; err_addr holds its value.
REQ-023 If cpu_ad moves to a new region while in WAIT (CPU protocol violation), the counter SHALL still run to zero; the decode and s_cs SHALL follow the new address.

Reset
REQ-024 While rst is low, asynchronously:
- state = IDLE, cnt = 0, sel_q = none, err = 0, err_addr = 0.
- cpu_rdy forced 1, s_cs = 0, s_we = 0, cpu_di = DFLT_DATA.
REQ-025 Reset asserted mid-wait SHALL abort the wait immediately. After release, the FSM SHALL restart evaluation from IDLE.

Verification
REQ-026 Read 16'h1234 (region 0, WS=0), slave 0 returns 8'hA5 -> s_cs=4'b0001, cpu_rdy stays 1, cpu_di=8'hA5 one cycle later.
REQ-027 Write 8'h3C to 16'h5000 (region 2, WS=2) -> cpu_rdy low for 2 cycles, s_cs=4'b0100 for 3 cycles, s_we high only in cycle 3 with s_wdata=8'h3C.
REQ-028 Access 16'h4000 (unmapped) -> s_cs=0, cpu_rdy=1, cpu_di=8'hFF next cycle, err=1, err_addr=16'h4000. A following unmapped 16'h7000 leaves err_addr unchanged.
REQ-029 err_clr pulsed alone -> err=0 next cycle. err_clr coincident with an unmapped access to 16'h4800 -> err=1, err_addr=16'h4800.
REQ-030 Overlap: set BASE_0=BASE_1 and access a shared address -> s_cs selects region 0 only.
REQ-031 rst driven low during the second wait cycle of a region-2 access -> cpu_rdy=1, s_cs=0 immediately. After release, re-presenting 16'h5000 yields the full 2-cycle wait.

Source files
------------

// File: rtl/bus_fabric.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_fabric : CPU address decoder with per-region wait states and error flag
// Rev 1.0
// ---------------------------------------------------------------------------
module bus_fabric #(
  parameter int                 NREG      = 4,
  parameter int                 AW        = 16,
  parameter int                 DW        = 8,
  parameter logic [NREG*AW-1:0] BASE      = {16'h6000, 16'h5000, 16'h8000, 16'h0000},
  parameter logic [NREG*AW-1:0] MASK      = {16'hF000, 16'hF000, 16'h8000, 16'hC000},
  parameter logic [NREG*4-1:0]  WS        = {4'd0, 4'd2, 4'd0, 4'd0},
  parameter logic [DW-1:0]      DFLT_DATA = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      cpu_ad,
  input  logic               cpu_we,
  input  logic [DW-1:0]      cpu_do,
  output logic [DW-1:0]      cpu_di,
  output logic               cpu_rdy,
  output logic [NREG-1:0]    s_cs,
  output logic               s_we,
  output logic [AW-1:0]      s_addr,
  output logic [DW-1:0]      s_wdata,
  input  logic [NREG*DW-1:0] s_rdata,
  input  logic               err_clr,
  output logic               err,
  output logic [AW-1:0]      err_addr
);

  localparam int            SW       = $clog2(NREG + 1);
  localparam logic [SW-1:0] SEL_NONE = SW'(NREG);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  logic [SW-1:0] hit_idx;
  logic [3:0]    hit_ws;
  logic          hit;
  logic          err_set;

  // Scan from the top down so the lowest-numbered matching region wins.
  always_comb begin
    hit_idx = SEL_NONE;
    hit_ws  = 4'd0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((cpu_ad & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        hit_idx = SW'(i);
        hit_ws  = WS[i*4 +: 4];
      end
    end
  end

  assign hit = (hit_idx != SEL_NONE);

  for (genvar g = 0; g < NREG; g++) begin : g_cs
    assign s_cs[g] = rst & (hit_idx == SW'(g));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpu_rdy = 1'b1;
    case (state_q)
      IDLE: begin
        if (hit && (hit_ws != 4'd0)) begin
          cpu_rdy = 1'b0;
          cnt_d   = hit_ws - 4'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The count runs out even if the CPU wanders to another region mid-wait.
        if (cnt_q != 4'd0) begin
          cpu_rdy = 1'b0;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst) cpu_rdy = 1'b1;
  end

  assign s_we    = rst & cpu_we & cpu_rdy & hit;
  assign s_addr  = cpu_ad;
  assign s_wdata = cpu_do;
  assign err_set = rst & cpu_rdy & ~hit;

  always_comb begin
    sel_d      = cpu_rdy ? hit_idx : sel_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_set) begin
      err_d = 1'b1;
      if (!err_q || err_clr) err_addr_d = cpu_ad;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    cpu_di = DFLT_DATA;
    for (int i = 0; i < NREG; i++) begin
      if (sel_q == SW'(i)) cpu_di = s_rdata[i*DW +: DW];
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sel_q      <= SEL_NONE;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule
`default_nettype wire
